// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit: 32-cycle radix-2 multiply (shift-add) and
// restoring divide, followed by a sign fix-up cycle that writes HI/LO and pulses done.
module mul_div_unit (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    state_t      state;
    logic [5:0]  cnt;
    logic [31:0] opb;      // multiplicand (multiply) or divisor magnitude (divide)
    logic [63:0] acc;      // multiply: {partial sum, multiplier}; divide: acc[31:0] = dividend/quotient
    logic [31:0] rem;
    logic        is_div;
    logic        neg_q;
    logic        neg_r;
    logic        div0;

    assign state_dbg = state;

    // Operand magnitudes at command acceptance.
    logic        op_signed;
    logic [31:0] mag_a;
    logic [31:0] mag_b;

    always_comb begin
        op_signed = ~op[0];
        mag_a     = (op_signed && rs_data[31]) ? (~rs_data + 32'd1) : rs_data;
        mag_b     = (op_signed && rt_data[31]) ? (~rt_data + 32'd1) : rt_data;
    end

    // One iteration of each datapath.
    logic [32:0] mul_sum;
    logic [32:0] part_rem;
    logic        div_ok;
    logic [31:0] rem_next;

    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opb : 32'd0)};
        part_rem = {rem, acc[31]};
        div_ok   = (part_rem >= {1'b0, opb});
        // Remainder stays below the divisor, so the difference always fits 32 bits.
        rem_next = div_ok ? (part_rem[31:0] - opb) : part_rem[31:0];
    end

    // Sign fix-up applied in FIN.
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    always_comb begin
        prod_fix = neg_q ? (~acc + 64'd1) : acc;
        quo_fix  = neg_q ? (~acc[31:0] + 32'd1) : acc[31:0];
        rem_fix  = neg_r ? (~rem + 32'd1) : rem;
        // Divide by zero leaves the dividend magnitude in rem; re-applying the
        // dividend sign restores the original rs value for hi.
        if (div0) begin
            quo_fix = 32'hFFFF_FFFF;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            cnt    <= 6'd0;
            opb    <= 32'd0;
            acc    <= 64'd0;
            rem    <= 32'd0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                opb    <= mag_b;
                                acc    <= {32'd0, mag_a};
                                rem    <= 32'd0;
                                is_div <= op[1];
                                neg_q  <= op_signed && (rs_data[31] ^ rt_data[31]);
                                neg_r  <= op_signed && op[1] && rs_data[31];
                                div0   <= op[1] && (rt_data == 32'd0);
                                cnt    <= 6'd0;
                                busy   <= 1'b1;
                                state  <= RUN;
                            end
                            OP_MTHI: hi <= rs_data;
                            OP_MTLO: lo <= rs_data;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (is_div) begin
                        rem        <= rem_next;
                        acc[31:0]  <= {acc[30:0], div_ok};
                    end else begin
                        acc <= {mul_sum, acc[31:1]};
                    end
                    if (cnt == 6'd31) begin
                        state <= FIN;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                FIN: begin
                    if (is_div) begin
                        lo <= quo_fix;
                        hi <= rem_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: a driver pushes expected {hi,lo} per command,
// a negedge monitor pops and compares on every done pulse.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  state_dbg;

    mul_div_unit dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .op        (op),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .state_dbg (state_dbg)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          done_cyc_q[$];
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;
    logic [31:0] cur_hi = 32'd0;
    logic [31:0] cur_lo = 32'd0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, want);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc_q.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done got hi=%h lo=%h expected no result", hi, lo);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({hi, lo} !== mon_exp) begin
                    errors++;
                    $display("FAIL result got hi=%h lo=%h expected hi=%h lo=%h",
                             hi, lo, mon_exp[63:32], mon_exp[31:0]);
                end
            end
        end
    end

    // Driver: issue one arithmetic op and follow it to completion.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo, input bit inject);
        int  lat;
        bit  seen;
        exp_q.push_back({exp_hi, exp_lo});
        @(negedge clk);
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_accept", {63'd0, busy}, 64'd1);
        lat  = 0;
        seen = 1'b0;
        for (int k = 1; k <= 60 && !seen; k++) begin
            @(negedge clk);
            if (inject && k == 5) begin
                start = 1'b1; op = 3'b101; rs_data = 32'hDEAD_BEEF; rt_data = 32'h1;
            end
            if (inject && k == 6) start = 1'b0;
            if (k == 10) check("hold_during_run", {hi, lo}, {cur_hi, cur_lo});
            if (done === 1'b1) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout got no done in 60 cycles expected done after 33");
        end else begin
            check("latency", 64'(lat), 64'd33);
            check("busy_at_done", {63'd0, busy}, 64'd0);
            @(negedge clk);
            check("done_one_cycle", {63'd0, done}, 64'd0);
            cur_hi = exp_hi;
            cur_lo = exp_lo;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got no finish expected finish before 100us");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        rstn = 1'b0; start = 1'b0; op = 3'b000; rs_data = 32'd0; rt_data = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_state", {62'd0, state_dbg}, 64'd0);
        rstn = 1'b1;

        run_op(3'b000, 32'hFFFF_FFFD, 32'd7,          32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op(3'b010, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op(3'b010, 32'd7,         32'hFFFF_FFFE,  32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        run_op(3'b011, 32'd100,       32'd7,          32'd2,         32'd14,        1'b1);
        check("mtlo_ignored_while_busy", {32'd0, lo}, 64'd14);
        run_op(3'b011, 32'd5,         32'd0,          32'd5,         32'hFFFF_FFFF, 1'b0);
        run_op(3'b010, 32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0);
        run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000, 1'b0);
        run_op(3'b000, 32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 32'd0,         1'b0);
        run_op(3'b001, 32'h1234_5678, 32'h10,         32'd1,         32'h2345_6780, 1'b0);

        // MTHI / MTLO while idle take effect at the accepting edge.
        @(negedge clk);
        start = 1'b1; op = 3'b100; rs_data = 32'h1234_5678;
        @(posedge clk);
        #1;
        check("mthi", {32'd0, hi}, {32'd0, 32'h1234_5678});
        check("mthi_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        op = 3'b101; rs_data = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        check("mtlo", {hi, lo}, {32'h1234_5678, 32'hCAFE_F00D});
        @(negedge clk);
        start = 1'b0;

        // start held high: one accepted op per 34-cycle window.
        n0 = done_cnt;
        exp_q.push_back({32'd0, 32'd15});
        exp_q.push_back({32'd0, 32'd15});
        @(negedge clk);
        start = 1'b1; op = 3'b001; rs_data = 32'd3; rt_data = 32'd5;
        repeat (68) @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        check("held_done_count", 64'(done_cnt - n0), 64'd2);
        check("held_spacing",
              64'((done_cyc_q.size() >= 2) ? (done_cyc_q[$] - done_cyc_q[$-1]) : 0), 64'd34);

        // Asynchronous reset in the middle of a MULTU aborts it.
        @(negedge clk);
        start = 1'b1; op = 3'b001; rs_data = 32'd3; rt_data = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        check("abort_state", {62'd0, state_dbg}, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        n0 = done_cnt;
        repeat (40) @(negedge clk);
        check("abort_no_done", 64'(done_cnt - n0), 64'd0);
        check("abort_hilo_after", {hi, lo}, 64'd0);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative HI/LO multiply/divide unit for the MIPS datapath. It consumes the two operand words produced by the register file read ports (rs on port 1, rt on port 2) and computes MULT/MULTU/DIV/DIVU over multiple cycles into architectural HI/LO registers. It also supports direct MTHI/MTLO writes. The controller stalls on `busy`; HI/LO are read back through `hi`/`lo` for MFHI/MFLO writeback into the register file.

## Interface
- No parameters. Operand and result width is fixed at 32 bits.
- `clk` input 1: clock, all state updates on posedge.
- `rstn` input 1: reset, asynchronous, active-low.
- `start` input 1: command strobe, sampled on posedge; accepted only when `busy`=0.
- `op` input 3: command code.
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - 110 and 111 are no-ops.
- `rs_data` input 32: operand A (multiplicand/dividend; MTHI/MTLO source).
- `rt_data` input 32: operand B (multiplier/divisor).
- `busy` output 1: operation in progress; new commands ignored.
- `done` output 1: one-cycle pulse, HI/LO just updated by MULT/MULTU/DIV/DIVU.
- `hi` output 32: HI register, driven directly from the flop.
- `lo` output 32: LO register, driven directly from the flop.

## Operation
- States:
  - IDLE: `busy`=0.
  - RUN: `busy`=1, 32 iterations.
  - FIN: `busy`=1, sign fix-up and HI/LO write.
- IDLE + `start` + op 000–011:
  - Latch operand magnitudes. Signed ops take two's-complement abs; unsigned ops use the raw value.
  - Latch result sign flags.
  - Clear the 6-bit iteration counter and go to RUN.
- IDLE + `start` + op 100: `hi` <= `rs_data` at that edge. Stay IDLE, no `done`.
- IDLE + `start` + op 101: `lo` <= `rs_data` at that edge. Stay IDLE, no `done`.
- IDLE + `start` + op 110/111: no state change.
- RUN, multiply: radix-2 shift-add into a 64-bit accumulator, one multiplier bit per cycle, LSB first.
- RUN, divide: restoring division, one quotient bit per cycle, MSB first. Uses a 33-bit partial remainder.
- RUN → FIN after the 32nd iteration (counter = 31).
- FIN, multiply:
  - Negate the 64-bit product if the signs differ (signed only).
  - {hi,lo} <= product.
- FIN, divide:
  - lo <= quotient, negated if dividend and divisor signs differ (signed).
  - hi <= remainder, negated if the dividend was negative (signed).
  - The remainder takes the sign of the dividend.
- FIN: pulse `done`=1 and return to IDLE.
- Divide by zero (`rt_data`=0, DIV or DIVU): runs full latency; result is lo=32'hFFFF_FFFF, hi=`rs_data` as latched. No trap, no sign fix-up applied.
- Signed overflow, DIV 32'h8000_0000 / 32'hFFFF_FFFF: lo=32'h8000_0000, hi=0.
- `start` while `busy`=1: ignored entirely, including MTHI/MTLO. The controller must hold the instruction until `busy`=0.
- `hi`/`lo` are unchanged during RUN. They update only in FIN or on MTHI/MTLO.

## Timing
- Reset (`rstn`=0, any time, asynchronous):
  - state=IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0.
  - An in-flight operation is aborted with no partial write.
- Command accepted at edge E0.
  - `busy` is 1 from after E0 until after E33.
  - Iterations occur at edges E1..E32.
  - The FIN write occurs at E33: `hi`/`lo` valid after E33, `done`=1 for exactly the cycle E33..E34, `busy`=0 after E33.
  - Total latency: 33 cycles from acceptance to result.
- Back-to-back: a new `start` may be sampled at E34, the first edge where `busy`=0. At E33 itself `busy` is still 1, so `start` there is ignored.
- MTHI/MTLO: single-cycle. The value is visible on `hi`/`lo` immediately after the accepting edge.
- Operands are sampled only at E0. Changes to `rs_data`/`rt_data` during RUN have no effect.

## Test plan
- Reset mid-op: start MULTU, deassert `rstn` at cycle 10 → immediately `busy`=0, `hi`=`lo`=0; no `done` pulse follows.
- MULT signed: rs=32'hFFFF_FFFD (-3), rt=7 → after 33 cycles hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB, `done` pulses once.
- MULTU: rs=rt=32'hFFFF_FFFF → hi=32'hFFFF_FFFE, lo=32'h0000_0001.
- DIV signed: rs=-7 (32'hFFFF_FFF9), rt=2 → lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1).
- DIVU: rs=100, rt=7 → lo=14, hi=2.
- DIVU by zero: rs=5, rt=0 → lo=32'hFFFF_FFFF, hi=5.
- MTHI 32'h1234_5678 while idle → `hi` updates next edge. `start` with MTLO during `busy` → ignored, `lo` keeps the final divide result.
- `start` held high continuously → exactly one accepted op per 34-cycle window.
